// File: rtl/vanilla_scoreboard_age_tracker.sv
`default_nettype none
// ============================================================================
// Module   : vanilla_scoreboard_age_tracker
// Purpose  : Counts outstanding long-latency writebacks per (register, class)
//            and tracks per-register busy age and worst-case age.
// Revision : 1.0 - initial release
// ============================================================================
module vanilla_scoreboard_age_tracker #(
    parameter int  REG_ELS     = 32,
    parameter int  CLASSES     = 4,
    parameter int  COUNT_WIDTH = 2,
    parameter int  AGE_WIDTH   = 16,
    localparam int REG_ADDR_W  = (REG_ELS > 1) ? $clog2(REG_ELS) : 1,
    localparam int CLASS_W     = (CLASSES > 1) ? $clog2(CLASSES) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       set_v_i,
    input  logic                       flush_i,
    input  logic [CLASS_W-1:0]         set_class_i,
    input  logic [REG_ADDR_W-1:0]      set_id_i,
    input  logic                       clear_v_i,
    input  logic [CLASS_W-1:0]         clear_class_i,
    input  logic [REG_ADDR_W-1:0]      clear_id_i,
    input  logic [REG_ADDR_W-1:0]      query_id_i,
    output logic [REG_ELS*CLASSES-1:0] pending_o,
    output logic [REG_ELS-1:0]         busy_o,
    output logic [AGE_WIDTH-1:0]       query_age_o,
    output logic [AGE_WIDTH-1:0]       max_age_o,
    output logic [REG_ADDR_W-1:0]      max_age_id_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int                     c_slots     = REG_ELS * CLASSES;
    localparam logic [COUNT_WIDTH-1:0] c_count_max = '1;
    localparam logic [AGE_WIDTH-1:0]   c_age_max   = '1;

    logic [COUNT_WIDTH-1:0] r_count   [c_slots];
    logic [COUNT_WIDTH-1:0] w_count_n [c_slots];
    logic [AGE_WIDTH-1:0]   r_age     [REG_ELS];
    logic [AGE_WIDTH-1:0]   w_age_n   [REG_ELS];
    logic [c_slots-1:0]     w_set_sel;
    logic [c_slots-1:0]     w_clr_sel;
    logic [REG_ELS-1:0]     w_busy_n;
    logic                   w_set_e;
    logic                   w_ovf_hit;
    logic                   w_unf_hit;
    logic [AGE_WIDTH-1:0]   w_top_age;
    logic [REG_ADDR_W-1:0]  w_top_id;
    logic [AGE_WIDTH-1:0]   r_max_age;
    logic [REG_ADDR_W-1:0]  r_max_id;
    logic                   r_ovf;
    logic                   r_unf;

    // A set and clear landing on the same slot cancel, regardless of count.
    always_comb begin
        w_set_e   = set_v_i & ~flush_i;
        w_ovf_hit = 1'b0;
        w_unf_hit = 1'b0;
        w_set_sel = '0;
        w_clr_sel = '0;
        w_busy_n  = '0;
        for (int r = 0; r < REG_ELS; r++) begin
            for (int c = 0; c < CLASSES; c++) begin
                w_set_sel[r*CLASSES+c] = w_set_e && (set_id_i == REG_ADDR_W'(r))
                                         && (set_class_i == CLASS_W'(c));
                w_clr_sel[r*CLASSES+c] = clear_v_i && (clear_id_i == REG_ADDR_W'(r))
                                         && (clear_class_i == CLASS_W'(c));
                w_count_n[r*CLASSES+c] = r_count[r*CLASSES+c];
                case ({w_set_sel[r*CLASSES+c], w_clr_sel[r*CLASSES+c]})
                    2'b10: begin
                        if (r_count[r*CLASSES+c] == c_count_max)
                            w_ovf_hit = 1'b1;
                        else
                            w_count_n[r*CLASSES+c] = r_count[r*CLASSES+c] + COUNT_WIDTH'(1);
                    end
                    2'b01: begin
                        if (r_count[r*CLASSES+c] == '0)
                            w_unf_hit = 1'b1;
                        else
                            w_count_n[r*CLASSES+c] = r_count[r*CLASSES+c] - COUNT_WIDTH'(1);
                    end
                    default: ;
                endcase
                w_busy_n[r] = w_busy_n[r] | (w_count_n[r*CLASSES+c] != '0);
            end
        end
        for (int r = 0; r < REG_ELS; r++) begin
            if (!w_busy_n[r])
                w_age_n[r] = '0;
            else if (r_age[r] == c_age_max)
                w_age_n[r] = r_age[r];
            else
                w_age_n[r] = r_age[r] + AGE_WIDTH'(1);
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        w_top_age = '0;
        w_top_id  = '0;
        for (int r = 0; r < REG_ELS; r++) begin
            if (r_age[r] > w_top_age) begin
                w_top_age = r_age[r];
                w_top_id  = REG_ADDR_W'(r);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < c_slots; i++) r_count[i] <= '0;
            for (int r = 0; r < REG_ELS; r++) r_age[r] <= '0;
            r_max_age <= '0;
            r_max_id  <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            for (int i = 0; i < c_slots; i++) r_count[i] <= w_count_n[i];
            for (int r = 0; r < REG_ELS; r++) r_age[r] <= w_age_n[r];
            if (w_top_age > r_max_age) begin
                r_max_age <= w_top_age;
                r_max_id  <= w_top_id;
            end
            if (w_ovf_hit) r_ovf <= 1'b1;
            if (w_unf_hit) r_unf <= 1'b1;
        end
    end

    always_comb begin
        pending_o = '0;
        busy_o    = '0;
        for (int r = 0; r < REG_ELS; r++) begin
            for (int c = 0; c < CLASSES; c++) begin
                pending_o[r*CLASSES+c] = (r_count[r*CLASSES+c] != '0);
                busy_o[r] = busy_o[r] | (r_count[r*CLASSES+c] != '0);
            end
        end
    end

    assign query_age_o  = r_age[query_id_i];
    assign max_age_o    = r_max_age;
    assign max_age_id_o = r_max_id;
    assign overflow_o   = r_ovf;
    assign underflow_o  = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_vanilla_scoreboard_age_tracker.sv
`default_nettype none
// Directed bench for vanilla_scoreboard_age_tracker; a second instance with a
// 4-bit age counter shares all inputs to exercise age saturation.
module tb_vanilla_scoreboard_age_tracker;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         set_v_i, flush_i, clear_v_i;
    logic [1:0]   set_class_i, clear_class_i;
    logic [4:0]   set_id_i, clear_id_i, query_id_i;

    logic [127:0] pending_o, s_pending_o;
    logic [31:0]  busy_o, s_busy_o;
    logic [15:0]  query_age_o, max_age_o;
    logic [3:0]   s_query_age_o, s_max_age_o;
    logic [4:0]   max_age_id_o, s_max_age_id_o;
    logic         overflow_o, underflow_o, s_overflow_o, s_underflow_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    vanilla_scoreboard_age_tracker u_dut (
        .clk_i(clk_i), .reset_i(reset_i), .set_v_i(set_v_i), .flush_i(flush_i),
        .set_class_i(set_class_i), .set_id_i(set_id_i), .clear_v_i(clear_v_i),
        .clear_class_i(clear_class_i), .clear_id_i(clear_id_i), .query_id_i(query_id_i),
        .pending_o(pending_o), .busy_o(busy_o), .query_age_o(query_age_o),
        .max_age_o(max_age_o), .max_age_id_o(max_age_id_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    vanilla_scoreboard_age_tracker #(.AGE_WIDTH(4)) u_dut_sat (
        .clk_i(clk_i), .reset_i(reset_i), .set_v_i(set_v_i), .flush_i(flush_i),
        .set_class_i(set_class_i), .set_id_i(set_id_i), .clear_v_i(clear_v_i),
        .clear_class_i(clear_class_i), .clear_id_i(clear_id_i), .query_id_i(query_id_i),
        .pending_o(s_pending_o), .busy_o(s_busy_o), .query_age_o(s_query_age_o),
        .max_age_o(s_max_age_o), .max_age_id_o(s_max_age_id_o),
        .overflow_o(s_overflow_o), .underflow_o(s_underflow_o)
    );

    task automatic idle();
        set_v_i = 0; flush_i = 0; clear_v_i = 0;
        set_class_i = 0; set_id_i = 0; clear_class_i = 0; clear_id_i = 0;
    endtask

    task automatic apply_reset();
        reset_i = 1; idle();
        @(negedge clk_i); @(negedge clk_i);
        reset_i = 0;
    endtask

    task automatic drive_set(input logic [4:0] id, input logic [1:0] cls);
        set_v_i = 1; set_id_i = id; set_class_i = cls;
    endtask

    task automatic drive_clear(input logic [4:0] id, input logic [1:0] cls);
        clear_v_i = 1; clear_id_i = id; clear_class_i = cls;
    endtask

    task automatic test_reset();
        reset_i = 1; idle(); query_id_i = 0;
        @(negedge clk_i); @(negedge clk_i);
        checks++; if (pending_o !== 128'd0) begin failures++; $display("FAIL reset_pending got=%0h exp=0", pending_o); end
        checks++; if (busy_o !== 32'd0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy_o); end
        checks++; if (query_age_o !== 16'd0) begin failures++; $display("FAIL reset_age got=%0d exp=0", query_age_o); end
        checks++; if ({max_age_o, max_age_id_o} !== 21'd0) begin failures++; $display("FAIL reset_max got=%0d/%0d exp=0/0", max_age_o, max_age_id_o); end
        checks++; if ({overflow_o, underflow_o} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {overflow_o, underflow_o}); end
        reset_i = 0;
    endtask

    task automatic test_age_basic();
        apply_reset();
        query_id_i = 5;
        drive_set(5, 2);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            idle();
            checks++; if (pending_o[22] !== 1'b1) begin failures++; $display("FAIL age_pending c%0d got=%b exp=1", k, pending_o[22]); end
            checks++; if (query_age_o !== 16'(k)) begin failures++; $display("FAIL age_value c%0d got=%0d exp=%0d", k, query_age_o, k); end
            checks++; if (max_age_o !== 16'(k-1)) begin failures++; $display("FAIL age_max_lag c%0d got=%0d exp=%0d", k, max_age_o, k-1); end
            if (k == 4) drive_clear(5, 2);
        end
        @(negedge clk_i);
        idle();
        checks++; if (pending_o !== 128'd0) begin failures++; $display("FAIL age_cleared got=%0h exp=0", pending_o); end
        checks++; if (query_age_o !== 16'd0) begin failures++; $display("FAIL age_zero got=%0d exp=0", query_age_o); end
        checks++; if (max_age_o !== 16'd4 || max_age_id_o !== 5'd5) begin failures++; $display("FAIL age_max got=%0d/%0d exp=4/5", max_age_o, max_age_id_o); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_set(3, 0);
            @(negedge clk_i);
            idle();
            checks++; if (pending_o[12] !== 1'b1) begin failures++; $display("FAIL ovf_pending set%0d got=%b exp=1", i, pending_o[12]); end
            checks++; if (overflow_o !== (i == 3)) begin failures++; $display("FAIL ovf_flag set%0d got=%b exp=%b", i, overflow_o, (i == 3)); end
        end
        for (int i = 0; i < 3; i++) begin
            drive_clear(3, 0);
            @(negedge clk_i);
            idle();
            checks++; if (pending_o[12] !== (i != 2)) begin failures++; $display("FAIL ovf_drain clr%0d got=%b exp=%b", i, pending_o[12], (i != 2)); end
            checks++; if (underflow_o !== 1'b0) begin failures++; $display("FAIL ovf_no_unf clr%0d got=%b exp=0", i, underflow_o); end
        end
        drive_clear(3, 0);
        @(negedge clk_i);
        idle();
        checks++; if (underflow_o !== 1'b1) begin failures++; $display("FAIL ovf_unf got=%b exp=1", underflow_o); end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
    endtask

    task automatic test_underflow();
        apply_reset();
        drive_clear(7, 1);
        @(negedge clk_i);
        idle();
        checks++; if (underflow_o !== 1'b1) begin failures++; $display("FAIL unf_flag got=%b exp=1", underflow_o); end
        checks++; if (pending_o !== 128'd0) begin failures++; $display("FAIL unf_pending got=%0h exp=0", pending_o); end
        @(negedge clk_i);
        checks++; if ({underflow_o, overflow_o} !== 2'b10) begin failures++; $display("FAIL unf_sticky got=%b exp=10", {underflow_o, overflow_o}); end
    endtask

    task automatic test_same_slot();
        apply_reset();
        drive_set(4, 3);
        @(negedge clk_i);
        drive_set(4, 3); drive_clear(4, 3);
        @(negedge clk_i);
        idle();
        checks++; if (pending_o !== (128'd1 << 19)) begin failures++; $display("FAIL same_slot_pending got=%0h exp=%0h", pending_o, 128'd1 << 19); end
        checks++; if ({overflow_o, underflow_o} !== 2'b00) begin failures++; $display("FAIL same_slot_flags got=%b exp=00", {overflow_o, underflow_o}); end
        drive_set(1, 0); drive_clear(4, 3);
        @(negedge clk_i);
        idle();
        checks++; if (busy_o !== 32'h0000_0002) begin failures++; $display("FAIL diff_slot_busy got=%0h exp=2", busy_o); end
        checks++; if (underflow_o !== 1'b0) begin failures++; $display("FAIL diff_slot_unf got=%b exp=0", underflow_o); end
    endtask

    task automatic test_flush_saturate();
        apply_reset();
        drive_set(9, 0); flush_i = 1;
        @(negedge clk_i);
        idle();
        checks++; if (pending_o !== 128'd0 || busy_o !== 32'd0) begin failures++; $display("FAIL flush got=%0h/%0h exp=0/0", pending_o, busy_o); end
        query_id_i = 9;
        drive_set(9, 0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            idle();
            if (k == 15) begin
                checks++; if (s_query_age_o !== 4'd15) begin failures++; $display("FAIL sat_reach got=%0d exp=15", s_query_age_o); end
            end
        end
        checks++; if (query_age_o !== 16'd20) begin failures++; $display("FAIL wide_age got=%0d exp=20", query_age_o); end
        checks++; if (max_age_o !== 16'd19 || max_age_id_o !== 5'd9) begin failures++; $display("FAIL wide_max got=%0d/%0d exp=19/9", max_age_o, max_age_id_o); end
        checks++; if (s_query_age_o !== 4'd15) begin failures++; $display("FAIL sat_age got=%0d exp=15", s_query_age_o); end
        checks++; if (s_max_age_o !== 4'd15 || s_max_age_id_o !== 5'd9) begin failures++; $display("FAIL sat_max got=%0d/%0d exp=15/9", s_max_age_o, s_max_age_id_o); end
        reset_i = 1;
        #1;
        checks++; if (pending_o !== 128'd0 || busy_o !== 32'd0 || query_age_o !== 16'd0) begin failures++; $display("FAIL midreset_state got=%0h/%0h/%0d exp=0/0/0", pending_o, busy_o, query_age_o); end
        checks++; if (max_age_o !== 16'd0 || max_age_id_o !== 5'd0) begin failures++; $display("FAIL midreset_max got=%0d/%0d exp=0/0", max_age_o, max_age_id_o); end
        checks++; if (s_query_age_o !== 4'd0 || s_max_age_o !== 4'd0 || s_busy_o !== 32'd0) begin failures++; $display("FAIL midreset_sat got=%0d/%0d/%0h exp=0/0/0", s_query_age_o, s_max_age_o, s_busy_o); end
        @(negedge clk_i);
        reset_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1; idle(); query_id_i = 0;
        test_reset();
        test_age_basic();
        test_overflow();
        test_underflow();
        test_same_slot();
        test_flush_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
